// File: rtl/miner_pkg.sv
// Shared command/status codes, job size and parser state type for the miner SPI command layer.
// MINER_JOB_CHECKSUM_EN appends one XOR checksum byte to every job load.
`default_nettype none

package miner_pkg;
  localparam int JOB_BYTES = 44;

  localparam logic [7:0] CMD_STATUS = 8'hF0;
  localparam logic [7:0] CMD_LOAD   = 8'hF1;
  localparam logic [7:0] CMD_NONCE  = 8'hF2;

  localparam logic [7:0] STAT_WAITING = 8'hA0;
  localparam logic [7:0] STAT_BUSY    = 8'hA1;
  localparam logic [7:0] STAT_FOUND   = 8'hA2;
  localparam logic [7:0] STAT_ERROR   = 8'hAE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STATUS_TX = 2'd1,
    LOAD      = 2'd2,
    NONCE_TX  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/job_shift_reg.sv
// Byte-wide job staging shift register with byte counter and last-byte flag.
// MINER_JOB_CHECKSUM_EN adds a trailing checksum byte checked against a running XOR.
`default_nettype none

module job_shift_reg #(
  parameter int NBYTES = 44
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            din,
  output logic [8*NBYTES-1:0]   payload,
  output logic                  at_last,
  output logic                  check_ok
);
  localparam int CW = $clog2(NBYTES + 2);

  logic [CW-1:0] count;

`ifdef MINER_JOB_CHECKSUM_EN
  localparam int TOTAL = NBYTES + 1;
  localparam int SW    = 8 * NBYTES;

  logic [SW-1:0] stage;
  logic [7:0]    xor_acc;

  // The checksum byte itself is compared, never shifted into the payload.
  assign payload  = stage;
  assign check_ok = (xor_acc == din);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stage   <= '0;
      xor_acc <= 8'h00;
    end else if (shift_en && (count != CW'(NBYTES))) begin
      stage   <= {stage[SW-9:0], din};
      xor_acc <= xor_acc ^ din;
    end
  end
`else
  localparam int TOTAL = NBYTES;
  localparam int SW    = 8 * (NBYTES - 1);

  logic [SW-1:0] stage;

  // The final byte is folded in combinationally so the job commits on its arrival cycle.
  assign payload  = {stage, din};
  assign check_ok = 1'b1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stage <= '0;
    end else if (shift_en) begin
      stage <= {stage[SW-9:0], din};
    end
  end
`endif

  assign at_last = (count == CW'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (shift_en) begin
      count <= count + CW'(1);
    end
  end
endmodule

`default_nettype wire

// File: rtl/spi_cmd_parser.sv
// SPI command parser: decodes host commands, assembles mining jobs and supplies response bytes.
// MINER_JOB_CHECKSUM_EN (via job_shift_reg) requires a trailing XOR byte on job loads.
`default_nettype none

module spi_cmd_parser
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ssel,
  input  logic         byte_received,
  input  logic [7:0]   received_data,
  input  logic         data_needed,
  output logic [7:0]   data_to_send,
  output logic [255:0] job_midstate,
  output logic [95:0]  job_tail,
  output logic         job_valid,
  input  logic         job_ready,
  input  logic         miner_busy,
  input  logic         nonce_found,
  input  logic [31:0]  nonce
);
  state_t state, state_next;

  logic        first_byte, found, err, discard, tx_has_nonce;
  logic [31:0] nonce_q, tx_word, tx_src;
  logic [1:0]  tx_idx, idx_next;
  logic        rx_ok, tx_ok, cmd_ok, shift_en, commit;
  logic        status_done, nonce_done, nonce_adv;
  logic [7:0]  status_byte, tx_byte;
  logic [8*JOB_BYTES-1:0] payload;
  logic        at_last, check_ok;

  assign rx_ok    = byte_received && !ssel;
  assign tx_ok    = data_needed && !ssel;
  assign cmd_ok   = (state == IDLE) && rx_ok && first_byte;
  assign shift_en = (state == LOAD) && rx_ok;
  assign commit   = shift_en && at_last;

  job_shift_reg #(.NBYTES(JOB_BYTES)) u_job_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != LOAD),
    .shift_en (shift_en),
    .din      (received_data),
    .payload  (payload),
    .at_last  (at_last),
    .check_ok (check_ok)
  );

  always_comb begin
    state_next  = state;
    status_done = 1'b0;
    nonce_done  = 1'b0;
    nonce_adv   = 1'b0;
    if (ssel) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ok) begin
            case (received_data)
              CMD_STATUS: state_next = STATUS_TX;
              CMD_LOAD:   state_next = LOAD;
              CMD_NONCE:  state_next = NONCE_TX;
              default:    state_next = IDLE;
            endcase
          end
        end
        STATUS_TX: begin
          if (tx_ok) begin
            state_next  = IDLE;
            status_done = 1'b1;
          end
        end
        LOAD: begin
          if (commit) state_next = IDLE;
        end
        NONCE_TX: begin
          if (tx_ok) begin
            nonce_adv = 1'b1;
            if (tx_idx == 2'd3) begin
              state_next = IDLE;
              nonce_done = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    status_byte = STAT_WAITING;
    if (found)                        status_byte = STAT_FOUND;
    else if (err)                     status_byte = STAT_ERROR;
    else if (miner_busy || job_valid) status_byte = STAT_BUSY;
  end

  // Outside NONCE_TX the snapshot is not yet registered, so use the live nonce.
  always_comb begin
    tx_src   = tx_word;
    idx_next = tx_idx + {1'b0, nonce_adv};
    if (state == IDLE) begin
      tx_src   = found ? nonce_q : 32'h0;
      idx_next = 2'd0;
    end
    tx_byte = tx_src[31:24];
    case (idx_next)
      2'd1:    tx_byte = tx_src[23:16];
      2'd2:    tx_byte = tx_src[15:8];
      2'd3:    tx_byte = tx_src[7:0];
      default: tx_byte = tx_src[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      first_byte   <= 1'b1;
      data_to_send <= 8'h00;
      job_midstate <= '0;
      job_tail     <= '0;
      job_valid    <= 1'b0;
      found        <= 1'b0;
      err          <= 1'b0;
      nonce_q      <= 32'h0;
      discard      <= 1'b0;
      tx_word      <= 32'h0;
      tx_has_nonce <= 1'b0;
      tx_idx       <= 2'd0;
    end else begin
      state      <= state_next;
      first_byte <= ssel ? 1'b1 : (byte_received ? 1'b0 : first_byte);
      tx_idx     <= idx_next;

      case (state_next)
        STATUS_TX: data_to_send <= status_byte;
        NONCE_TX:  data_to_send <= tx_byte;
        default:   data_to_send <= 8'h00;
      endcase

      if (cmd_ok && (received_data == CMD_NONCE)) begin
        tx_word      <= found ? nonce_q : 32'h0;
        tx_has_nonce <= found;
      end
      if (cmd_ok && (received_data == CMD_LOAD)) discard <= job_valid;

      if (status_done) err <= 1'b0;
      if ((cmd_ok && (received_data == CMD_LOAD) && job_valid) ||
          (cmd_ok && (received_data == CMD_NONCE) && !found) ||
          (commit && !check_ok))
        err <= 1'b1;

      // A fresh nonce takes priority over the clear at the end of a nonce read.
      if (nonce_found) begin
        found   <= 1'b1;
        nonce_q <= nonce;
      end else if (nonce_done && tx_has_nonce) begin
        found <= 1'b0;
      end

      if (commit && !discard && check_ok) begin
        job_midstate <= payload[8*JOB_BYTES-1:96];
        job_tail     <= payload[95:0];
        job_valid    <= 1'b1;
      end else if (job_valid && job_ready) begin
        job_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_parser.sv
// Self-checking bench for spi_cmd_parser: status/nonce vector table, hand-written corner
// sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps

module tb_spi_cmd_parser;
  import miner_pkg::*;

  logic         clk = 1'b0;
  logic         reset, ssel, byte_received, data_needed;
  logic [7:0]   received_data, data_to_send;
  logic [255:0] job_midstate;
  logic [95:0]  job_tail;
  logic         job_valid, job_ready, miner_busy, nonce_found;
  logic [31:0]  nonce;

  always #5 clk = ~clk;

  spi_cmd_parser dut (
    .clk(clk), .reset(reset), .ssel(ssel),
    .byte_received(byte_received), .received_data(received_data),
    .data_needed(data_needed), .data_to_send(data_to_send),
    .job_midstate(job_midstate), .job_tail(job_tail), .job_valid(job_valid),
    .job_ready(job_ready), .miner_busy(miner_busy),
    .nonce_found(nonce_found), .nonce(nonce)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0]   pl [JOB_BYTES];
  logic         m_jv, m_found, m_err;
  logic [255:0] m_mid;
  logic [95:0]  m_tail;
  logic [31:0]  m_nonce;

  typedef struct {
    bit          inject;
    logic [31:0] nv;
    bit          busy;
    logic [7:0]  exp_status;
    bit          do_read;
    logic [31:0] exp_word;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(); ssel = 1'b0; step(2); endtask
  task automatic frame_end();   ssel = 1'b1; step(2); endtask

  task automatic pulse_rx(input logic [7:0] b);
    received_data = b; byte_received = 1'b1; step();
    byte_received = 1'b0; step();
  endtask

  task automatic get_tx(output logic [7:0] b);
    data_needed = 1'b1; b = data_to_send; step();
    data_needed = 1'b0; step();
  endtask

  task automatic cmd_status(output logic [7:0] b);
    frame_begin(); pulse_rx(CMD_STATUS); get_tx(b); frame_end();
  endtask

  task automatic read_nonce(output logic [31:0] w);
    logic [7:0] b;
    frame_begin(); pulse_rx(CMD_NONCE);
    for (int i = 0; i < 4; i++) begin get_tx(b); w = {w[23:0], b}; end
    frame_end();
  endtask

  task automatic inject_nonce(input logic [31:0] v);
    nonce = v; nonce_found = 1'b1; step(); nonce_found = 1'b0; step();
  endtask

  task automatic handshake();
    job_ready = 1'b1; step(); job_ready = 1'b0; step();
  endtask

  task automatic pack(output logic [255:0] m, output logic [95:0] t);
    m = '0; t = '0;
    for (int i = 0; i < 32; i++)        m = {m[247:0], pl[i]};
    for (int i = 32; i < JOB_BYTES; i++) t = {t[87:0], pl[i]};
  endtask

  // Sends 0xF1 plus the first n payload bytes (and the checksum byte when enabled).
  task automatic do_load(input int n, input bit timing, input bit dn, input bit bad_sum);
    logic [7:0] q [$];
    logic [7:0] x;
    x = bad_sum ? 8'hFF : 8'h00;
    for (int i = 0; i < n; i++) begin q.push_back(pl[i]); x = x ^ pl[i]; end
`ifdef MINER_JOB_CHECKSUM_EN
    if (n == JOB_BYTES) q.push_back(x);
`endif
    frame_begin(); pulse_rx(CMD_LOAD);
    foreach (q[i]) begin
      if (timing && i == q.size() - 1) check("jv_before_last", job_valid, 0);
      received_data = q[i]; byte_received = 1'b1; data_needed = dn;
      if (dn && i == 0) check("dts_during_load", data_to_send, 0);
      step();
      byte_received = 1'b0; data_needed = 1'b0;
      if (timing && i == q.size() - 1) check("jv_rise", job_valid, 1);
      step();
    end
    frame_end();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]   b;
    logic [31:0]  w;
    logic [255:0] em;
    logic [95:0]  et;

    reset = 1'b1; ssel = 1'b1; byte_received = 1'b0; received_data = 8'h00;
    data_needed = 1'b0; job_ready = 1'b0; miner_busy = 1'b0;
    nonce_found = 1'b0; nonce = 32'h0;
    step(3);
    reset = 1'b0; step();

    check("rst_dts", data_to_send, 0);
    check("rst_jv", job_valid, 0);
    check("rst_mid", job_midstate, 0);
    check("rst_tail", job_tail, 0);

    tbl[0]  = '{0, 32'h0,        0, 8'hA0, 0, 32'h0};
    tbl[1]  = '{0, 32'h0,        1, 8'hA1, 0, 32'h0};
    tbl[2]  = '{1, 32'hDEADBEEF, 0, 8'hA2, 1, 32'hDEADBEEF};
    tbl[3]  = '{0, 32'h0,        0, 8'hA0, 0, 32'h0};
    tbl[4]  = '{1, 32'h12345678, 1, 8'hA2, 1, 32'h12345678};
    tbl[5]  = '{0, 32'h0,        1, 8'hA1, 0, 32'h0};
    tbl[6]  = '{0, 32'h0,        0, 8'hA0, 1, 32'h0};
    tbl[7]  = '{0, 32'h0,        0, 8'hAE, 0, 32'h0};
    tbl[8]  = '{0, 32'h0,        1, 8'hA1, 0, 32'h0};
    tbl[9]  = '{1, 32'h11111111, 0, 8'hA2, 0, 32'h0};
    tbl[10] = '{1, 32'hCAFEF00D, 0, 8'hA2, 1, 32'hCAFEF00D};
    tbl[11] = '{0, 32'h0,        0, 8'hA0, 0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      miner_busy = tbl[i].busy;
      if (tbl[i].inject) inject_nonce(tbl[i].nv);
      cmd_status(b);
      check($sformatf("tbl%0d_status", i), b, tbl[i].exp_status);
      if (tbl[i].do_read) begin
        read_nonce(w);
        check($sformatf("tbl%0d_nonce", i), w, tbl[i].exp_word);
      end
    end
    miner_busy = 1'b0;

    // Full load 0x00..0x2B with data_needed overlapping every payload byte.
    for (int i = 0; i < JOB_BYTES; i++) pl[i] = 8'(i);
    do_load(JOB_BYTES, 1, 1, 0);
    check("load_mid", job_midstate,
          256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
    check("load_tail", job_tail, 96'h202122232425262728292A2B);
    check("jv_held", job_valid, 1);
    handshake();
    check("jv_clear", job_valid, 0);

    // Aborted load, then a full load with a new pattern.
    for (int i = 0; i < JOB_BYTES; i++) pl[i] = 8'hFF - 8'(i);
    do_load(20, 0, 0, 0);
    cmd_status(b);
    check("abort_status", b, 8'hA0);
    check("abort_jv", job_valid, 0);
    do_load(JOB_BYTES, 0, 0, 0);
    pack(em, et);
    check("reload_jv", job_valid, 1);
    check("reload_mid", job_midstate, em);
    check("reload_tail", job_tail, et);

    // Second load while the first job is still pending.
    for (int i = 0; i < JOB_BYTES; i++) pl[i] = 8'(3 * i + 7);
    do_load(JOB_BYTES, 0, 0, 0);
    check("pend_mid", job_midstate, em);
    check("pend_tail", job_tail, et);
    cmd_status(b);
    check("pend_status_err", b, 8'hAE);
    cmd_status(b);
    check("pend_status_busy", b, 8'hA1);
    handshake();

    // nonce_found on the same cycle as the final nonce byte: the new nonce survives.
    inject_nonce(32'hAAAA5555);
    frame_begin(); pulse_rx(CMD_NONCE);
    for (int i = 0; i < 3; i++) begin get_tx(b); w = {w[23:0], b}; end
    data_needed = 1'b1; nonce_found = 1'b1; nonce = 32'h0BADCAFE;
    b = data_to_send; w = {w[23:0], b};
    step();
    data_needed = 1'b0; nonce_found = 1'b0; step();
    frame_end();
    check("race_bytes", w, 32'hAAAA5555);
    cmd_status(b);
    check("race_status", b, 8'hA2);
    read_nonce(w);
    check("race_new_nonce", w, 32'h0BADCAFE);
    cmd_status(b);
    check("race_after", b, 8'hA0);

`ifdef MINER_JOB_CHECKSUM_EN
    do_load(JOB_BYTES, 0, 0, 1);
    check("badsum_jv", job_valid, 0);
    cmd_status(b);
    check("badsum_status", b, 8'hAE);
`endif

    // Reset in the middle of a load.
    frame_begin(); pulse_rx(CMD_LOAD);
    for (int i = 0; i < 20; i++) pulse_rx(pl[i]);
    reset = 1'b1; step(); reset = 1'b0;
    frame_end();
    check("rstload_jv", job_valid, 0);
    check("rstload_mid", job_midstate, 0);
    cmd_status(b);
    check("rstload_status", b, 8'hA0);

    // Randomized transactions against the model.
    m_jv = 0; m_found = 0; m_err = 0; m_mid = '0; m_tail = '0; m_nonce = '0;
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 5));
      miner_busy = 1'($urandom_range(0, 1));
      case (op)
        0: begin
          cmd_status(b);
          check("rnd_status", b, m_found ? 8'hA2 : m_err ? 8'hAE :
                (miner_busy || m_jv) ? 8'hA1 : 8'hA0);
          m_err = 0;
        end
        1: begin
          for (int i = 0; i < JOB_BYTES; i++) pl[i] = 8'($urandom);
          do_load(JOB_BYTES, 0, 0, 0);
          if (m_jv) m_err = 1;
          else begin pack(m_mid, m_tail); m_jv = 1; end
        end
        2: begin
          if (!m_jv) do_load(int'($urandom_range(0, JOB_BYTES - 1)), 0, 0, 0);
        end
        3: begin
          m_nonce = $urandom; m_found = 1;
          inject_nonce(m_nonce);
        end
        4: begin
          read_nonce(w);
          check("rnd_nonce", w, m_found ? m_nonce : 32'h0);
          if (!m_found) m_err = 1;
          m_found = 0;
        end
        default: begin
          handshake();
          m_jv = 0;
        end
      endcase
      check("rnd_jv", job_valid, m_jv);
      check("rnd_mid", job_midstate, m_mid);
      check("rnd_tail", job_tail, m_tail);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/spi_cmd_parser.md
# spi_cmd_parser

Command layer directly downstream of the SPI slave byte interface in the bitcoin miner. Consumes received command and data bytes and assembles 44-byte mining jobs (32-byte midstate plus 12-byte header tail) for the hasher. Supplies the response byte for each SPI transfer: status, or a found nonce. Replaces the fixed status-only responder; the SPI byte engine stays a separate instance.

## Interface
- `JOB_BYTES`, 44: bytes per job payload; midstate first, then tail, MSB first.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ssel`  in  1  SPI select, active low; high aborts any frame in progress.
- `byte_received`  in  1  one-cycle pulse; `received_data` is valid on this cycle.
- `received_data`  in  8  byte from the host.
- `data_needed`  in  1  one-cycle pulse; the slave samples `data_to_send` on this cycle.
- `data_to_send`  out  8  next response byte.
- `job_midstate`  out  256  job midstate; stable while `job_valid` is high.
- `job_tail`  out  96  header tail (merkle tail, time, bits).
- `job_valid`  out  1  job offered to the hasher.
- `job_ready`  in  1  hasher accepts the job when both valid and ready are high.
- `miner_busy`  in  1  hasher is searching.
- `nonce_found`  in  1  one-cycle pulse; `nonce` is valid on this cycle.
- `nonce`  in  32  winning nonce.

## Operation
- Commands (first byte after `ssel` falls):
  - 0xF0: status.
  - 0xF1: load job; followed by `JOB_BYTES` data bytes.
  - 0xF2: read nonce.
  - Any other value: ignored; parser stays in IDLE.
- Status byte priority:
  - FOUND 0xA2 if the found flag is set;
  - else ERROR 0xAE if the err flag is set;
  - else BUSY 0xA1 if `miner_busy` or `job_valid` is high;
  - else WAITING 0xA0.
- FSM states: IDLE, STATUS_TX, LOAD, NONCE_TX.
  - IDLE --0xF0--> STATUS_TX.
  - IDLE --0xF1--> LOAD, byte counter = 0.
  - IDLE --0xF2--> NONCE_TX, counter = 0.
- STATUS_TX:
  - Response register is loaded with the status byte.
  - On the next `data_needed`, return to IDLE and clear the err flag.
- LOAD:
  - Each `byte_received` shifts the byte into a 352-bit staging register and increments the counter.
  - When the counter reaches `JOB_BYTES`, copy staging into the job outputs, set `job_valid`, and return to IDLE.
  - If `job_valid` is already high when 0xF1 arrives, the parser stays in LOAD and consumes the bytes but discards the job and sets err.
- NONCE_TX:
  - Serves latched nonce bytes MSB first on successive `data_needed` pulses.
  - After the 4th byte, clear the found flag and return to IDLE.
  - If the found flag is clear at 0xF2, send 0x00 ×4 and set err.
- `job_valid` clears on the cycle after `job_valid && job_ready`.
- `nonce_found` latches `nonce` and sets the found flag.
  - A new `nonce_found` overwrites an unread nonce.
  - When `nonce_found` coincides with the clear at the end of NONCE_TX, the set wins.
- `ssel` high in any state: return to IDLE next cycle and drop partial staging. Job outputs, flags and the latched nonce are kept.
- With no response pending, `data_to_send` = 0x00.

## Timing
- Reset values:
  - `data_to_send` 0x00, `job_valid` 0, job outputs 0;
  - found/err flags 0, latched nonce 0;
  - state IDLE.
- Response byte is registered on the cycle after the command's `byte_received`. It must be valid before the next `data_needed`, which is at least 8 `sck` periods later.
- `job_valid` rises 1 cycle after the final payload `byte_received`.
- `byte_received` and `data_needed` on the same cycle: both are processed; the RX path and the TX path are independent.
- Reset mid-LOAD: abandon the staging register; no `job_valid`.

## Configuration
- `MINER_JOB_CHECKSUM_EN` defined:
  - LOAD expects `JOB_BYTES`+1 bytes. The last byte must equal the XOR of all payload bytes.
  - On mismatch, the job is discarded, err is set, and `job_valid` stays 0.
- Undefined: no checksum byte; the job is committed after `JOB_BYTES` bytes.

## Structure
- `miner_pkg` holds:
  - command codes (0xF0/0xF1/0xF2) and status codes (0xA0/0xA1/0xA2/0xAE);
  - `JOB_BYTES`;
  - the FSM state enum.
- Sub-module `job_shift_reg`: byte-wide shift register with counter, complete flag and optional XOR accumulator. The FSM, flags and response mux stay in the top.

## Test plan
- After reset, 0xF0 -> next `data_to_send` 0xA0; `job_valid` 0.
- 0xF1 + 44 bytes 0x00..0x2B -> `job_midstate` = 0x000102…1F, `job_tail` = 0x20…2B, `job_valid` rises 1 cycle after the last byte and clears after `job_ready`.
- `nonce_found` with `nonce` 0xDEADBEEF, then 0xF0 -> 0xA2; then 0xF2 -> 0xDE, 0xAD, 0xBE, 0xEF; then 0xF0 -> 0xA0 (or 0xA1 if busy).
- 0xF1 + 20 bytes, `ssel` high, then 0xF0 -> 0xA0, no `job_valid`; a following full load succeeds.
- Second 0xF1 load while `job_valid` is pending with `job_ready` 0 -> job outputs unchanged; 0xF0 -> 0xAE, then the next 0xF0 -> 0xA1.
- With `MINER_JOB_CHECKSUM_EN`: correct XOR byte -> job committed; wrong byte -> no `job_valid`, status 0xAE.
